// File: rtl/uart_rx_fifo.sv
// Receive-side character buffer: stores {parity_error, data} on each rx_done pulse, FWFT drain.
// Latency: a write on edge N is visible at rd_valid_o/rd_data_o after edge N; no empty bypass.
// Backpressure: rd_ready_i stalls the head; writes arriving while full (and not draining) are dropped and flagged.
module uart_rx_fifo #(
    parameter int MAX_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int ADDR_WIDTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clr_i,
    input  logic                      rx_done_i,
    input  logic [MAX_DATA_WIDTH-1:0] rx_data_i,
    input  logic                      parity_error_i,
    input  logic                      rd_ready_i,
    output logic                      rd_valid_o,
    output logic [MAX_DATA_WIDTH-1:0] rd_data_o,
    output logic                      rd_parity_error_o,
    output logic [ADDR_WIDTH:0]       count_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      overflow_o
);

    typedef struct packed {
        logic                      par;
        logic [MAX_DATA_WIDTH-1:0] dat;
    } entry_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);

    entry_t                mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  rd_fire;
    logic                  wr;
    logic                  drop;
    entry_t                head;

    assign empty_o    = (count == '0);
    assign full_o     = (count == DEPTH_C);
    assign rd_valid_o = ~empty_o;
    assign count_o    = count;
    assign overflow_o = overflow;

    assign rd_fire = rd_valid_o & rd_ready_i;
    assign wr      = rx_done_i & (~full_o | rd_fire);
    assign drop    = rx_done_i & full_o & ~rd_fire;

    // Head is forced to zero while empty so the outputs never expose stale storage.
    assign head              = mem[rd_ptr];
    assign rd_data_o         = rd_valid_o ? head.dat : '0;
    assign rd_parity_error_o = rd_valid_o & head.par;

    always_ff @(posedge clk_i) begin
        if (rst_ni && !clr_i && wr) begin
            mem[wr_ptr] <= '{par: parity_error_i, dat: rx_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one task per scenario, inline comparisons, single summary line.
module tb_uart_rx_fifo;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       clr_i = 1'b0;
    logic       rx_done_i = 1'b0;
    logic [7:0] rx_data_i = 8'h00;
    logic       parity_error_i = 1'b0;
    logic       rd_ready_i = 1'b0;
    logic       rd_valid_o;
    logic [7:0] rd_data_o;
    logic       rd_parity_error_o;
    logic [4:0] count_o;
    logic       full_o;
    logic       empty_o;
    logic       overflow_o;

    int errors = 0;
    int checks = 0;

    uart_rx_fifo #(
        .MAX_DATA_WIDTH(8),
        .FIFO_DEPTH    (16),
        .ADDR_WIDTH    (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .clr_i            (clr_i),
        .rx_done_i        (rx_done_i),
        .rx_data_i        (rx_data_i),
        .parity_error_i   (parity_error_i),
        .rd_ready_i       (rd_ready_i),
        .rd_valid_o       (rd_valid_o),
        .rd_data_o        (rd_data_o),
        .rd_parity_error_o(rd_parity_error_o),
        .count_o          (count_o),
        .full_o           (full_o),
        .empty_o          (empty_o),
        .overflow_o       (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_one(input logic [7:0] d, input logic p);
        rx_done_i      = 1'b1;
        rx_data_i      = d;
        parity_error_i = p;
        tick();
        rx_done_i      = 1'b0;
        parity_error_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        checks++; if (empty_o !== 1'b1)    begin errors++; $display("FAIL reset_empty got=%b exp=1", empty_o); end
        checks++; if (full_o !== 1'b0)     begin errors++; $display("FAIL reset_full got=%b exp=0", full_o); end
        checks++; if (count_o !== 5'd0)    begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", rd_valid_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow_o); end
        checks++; if (rd_data_o !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", rd_data_o); end
        checks++; if (rd_parity_error_o !== 1'b0) begin errors++; $display("FAIL reset_parity got=%b exp=0", rd_parity_error_o); end
    endtask

    task automatic test_single();
        write_one(8'hA5, 1'b1);
        checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", rd_valid_o); end
        checks++; if (rd_data_o !== 8'hA5) begin errors++; $display("FAIL single_data got=%h exp=a5", rd_data_o); end
        checks++; if (rd_parity_error_o !== 1'b1) begin errors++; $display("FAIL single_parity got=%b exp=1", rd_parity_error_o); end
        checks++; if (count_o !== 5'd1)    begin errors++; $display("FAIL single_count got=%0d exp=1", count_o); end
        rd_ready_i = 1'b1;
        tick();
        rd_ready_i = 1'b0;
        checks++; if (count_o !== 5'd0)    begin errors++; $display("FAIL single_count_after_read got=%0d exp=0", count_o); end
        checks++; if (empty_o !== 1'b1)    begin errors++; $display("FAIL single_empty_after_read got=%b exp=1", empty_o); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) write_one(8'(i), i[0]);
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fill_no_overflow_yet got=%b exp=0", overflow_o); end
        write_one(8'h55, 1'b0);
        checks++; if (full_o !== 1'b1)     begin errors++; $display("FAIL fill_full got=%b exp=1", full_o); end
        checks++; if (count_o !== 5'd16)   begin errors++; $display("FAIL fill_count got=%0d exp=16", count_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL fill_overflow got=%b exp=1", overflow_o); end
        rd_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL drain_valid idx=%0d got=%b exp=1", i, rd_valid_o); end
            checks++; if (rd_data_o !== 8'(i)) begin errors++; $display("FAIL drain_data idx=%0d got=%h exp=%h", i, rd_data_o, 8'(i)); end
            checks++; if (rd_parity_error_o !== i[0]) begin errors++; $display("FAIL drain_parity idx=%0d got=%b exp=%b", i, rd_parity_error_o, i[0]); end
            tick();
        end
        rd_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1)    begin errors++; $display("FAIL drain_empty got=%b exp=1 (0x55 must be absent)", empty_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL drain_overflow_sticky got=%b exp=1", overflow_o); end
    endtask

    task automatic test_full_rw();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL clr_overflow got=%b exp=0", overflow_o); end
        for (int i = 0; i < 16; i++) write_one(8'(i), 1'b0);
        checks++; if (full_o !== 1'b1)     begin errors++; $display("FAIL fullrw_full got=%b exp=1", full_o); end
        rd_ready_i = 1'b1;
        write_one(8'h77, 1'b1);
        checks++; if (count_o !== 5'd16)   begin errors++; $display("FAIL fullrw_count got=%0d exp=16", count_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL fullrw_overflow got=%b exp=0", overflow_o); end
        for (int i = 1; i < 16; i++) begin
            checks++; if (rd_data_o !== 8'(i)) begin errors++; $display("FAIL fullrw_data idx=%0d got=%h exp=%h", i, rd_data_o, 8'(i)); end
            tick();
        end
        checks++; if (rd_data_o !== 8'h77) begin errors++; $display("FAIL fullrw_tail got=%h exp=77", rd_data_o); end
        checks++; if (rd_parity_error_o !== 1'b1) begin errors++; $display("FAIL fullrw_tail_parity got=%b exp=1", rd_parity_error_o); end
        tick();
        rd_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1)    begin errors++; $display("FAIL fullrw_empty got=%b exp=1", empty_o); end
    endtask

    task automatic test_back_to_back();
        rd_ready_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            rx_done_i = 1'b1;
            rx_data_i = 8'(8'h80 + k);
            if (k > 0) begin
                checks++; if (rd_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid k=%0d got=%b exp=1", k, rd_valid_o); end
                checks++; if (rd_data_o !== 8'(8'h80 + k - 1)) begin errors++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rd_data_o, 8'(8'h80 + k - 1)); end
            end else begin
                checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass got=%b exp=0", rd_valid_o); end
            end
            tick();
            checks++; if (count_o !== 5'd1) begin errors++; $display("FAIL b2b_count k=%0d got=%0d exp=1", k, count_o); end
        end
        rx_done_i = 1'b0;
        checks++; if (rd_data_o !== 8'hA7) begin errors++; $display("FAIL b2b_last got=%h exp=a7", rd_data_o); end
        tick();
        rd_ready_i = 1'b0;
        checks++; if (empty_o !== 1'b1)    begin errors++; $display("FAIL b2b_empty got=%b exp=1", empty_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL b2b_overflow got=%b exp=0", overflow_o); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 17; i++) write_one(8'(8'h10 + i), 1'b0);
        rd_ready_i = 1'b1;
        for (int i = 0; i < 11; i++) tick();
        rd_ready_i = 1'b0;
        checks++; if (count_o !== 5'd5)    begin errors++; $display("FAIL flush_pre_count got=%0d exp=5", count_o); end
        checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL flush_pre_overflow got=%b exp=1", overflow_o); end
        checks++; if (rd_data_o !== 8'h1B) begin errors++; $display("FAIL flush_pre_head got=%h exp=1b", rd_data_o); end
        clr_i      = 1'b1;
        rx_done_i  = 1'b1;
        rx_data_i  = 8'h3C;
        rd_ready_i = 1'b1;
        tick();
        clr_i      = 1'b0;
        rx_done_i  = 1'b0;
        rd_ready_i = 1'b0;
        checks++; if (count_o !== 5'd0)    begin errors++; $display("FAIL flush_count got=%0d exp=0", count_o); end
        checks++; if (empty_o !== 1'b1)    begin errors++; $display("FAIL flush_empty got=%b exp=1", empty_o); end
        checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL flush_overflow got=%b exp=0", overflow_o); end
        tick();
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL flush_3c_not_stored got=%b exp=0", rd_valid_o); end
    endtask

    task automatic test_reset_mid();
        write_one(8'hC1, 1'b0);
        write_one(8'hC2, 1'b1);
        checks++; if (count_o !== 5'd2)    begin errors++; $display("FAIL rstmid_pre_count got=%0d exp=2", count_o); end
        rst_ni    = 1'b0;
        rx_done_i = 1'b1;
        rx_data_i = 8'hEE;
        tick();
        rst_ni    = 1'b1;
        rx_done_i = 1'b0;
        checks++; if (count_o !== 5'd0)    begin errors++; $display("FAIL rstmid_count got=%0d exp=0", count_o); end
        checks++; if (rd_valid_o !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", rd_valid_o); end
        write_one(8'h5A, 1'b0);
        checks++; if (rd_data_o !== 8'h5A) begin errors++; $display("FAIL rstmid_fresh_head got=%h exp=5a", rd_data_o); end
        checks++; if (count_o !== 5'd1)    begin errors++; $display("FAIL rstmid_fresh_count got=%0d exp=1", count_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_rw();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
